hmat_colmult_engine: RTL and testbench

//  Parametrised complex matrix engine: P = H x A, with H NR x NC and A NC x NCOL, signed fixed-point QI.FW.
//  H and A sit in write-loadable register files, not constant tables.
//  A start/busy/done handshake runs one multiply; P is presented as packed output columns for the SOML

---
 rtl/hmat_colmult_engine.sv | 233 +++++++++++++++++++++++
 tb/tb_hmat_colmult_engine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hmat_colmult_engine.sv
// Complex matrix product engine P = H x A over write-loadable H/A register files.
// Signed fixed-point elements (DW bits, FW fractional), 2-stage complex multiplier,
// per-element accumulation, packed column-major P output with start/busy/done handshake.
// Optional build macro: HQA_SAT_EN (saturating reduction of the accumulator to DW bits).
module hmat_colmult_engine #(
  parameter int unsigned DW   = 16,
  parameter int unsigned FW   = 8,
  parameter int unsigned NR   = 4,
  parameter int unsigned NC   = 2,
  parameter int unsigned NCOL = 2,
  localparam int unsigned HN   = NR * NC,
  localparam int unsigned AN   = NC * NCOL,
  localparam int unsigned MAXN = (HN > AN) ? HN : AN,
  localparam int unsigned AW   = (MAXN > 1) ? $clog2(MAXN) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DW-1:0]            wr_data_r,
  input  logic [DW-1:0]            wr_data_i,
  output logic                     wr_err,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [NCOL*NR*DW-1:0]    p_r,
  output logic [NCOL*NR*DW-1:0]    p_i
);

  localparam int unsigned HIW = (HN > 1) ? $clog2(HN) : 1;
  localparam int unsigned AIW = (AN > 1) ? $clog2(AN) : 1;
  localparam int unsigned KW  = (NC > 1) ? $clog2(NC) : 1;
  localparam int unsigned RW  = (NR > 1) ? $clog2(NR) : 1;
  localparam int unsigned CW  = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int unsigned MW  = 2 * DW;
  localparam int unsigned PW  = 2 * DW + 1;
  localparam int unsigned ACW = DW + FW + $clog2(NC) + 2;
  localparam int unsigned PN  = NCOL * NR;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state;
  logic [KW-1:0]          k;
  logic [RW-1:0]          r;
  logic [CW-1:0]          c;
  logic                   dcnt;

  logic signed [DW-1:0]   h_r [HN];
  logic signed [DW-1:0]   h_i [HN];
  logic signed [DW-1:0]   a_r [AN];
  logic signed [DW-1:0]   a_i [AN];

  logic                   s1_v, s1_first, s1_last;
  logic [RW-1:0]          s1_r;
  logic [CW-1:0]          s1_c;
  logic signed [MW-1:0]   s1_rr, s1_ii, s1_ri, s1_ir;
  logic                   s2_v, s2_first, s2_last;
  logic [RW-1:0]          s2_r;
  logic [CW-1:0]          s2_c;
  logic signed [PW-1:0]   s2_pr, s2_pi;
  logic signed [ACW-1:0]  acc_r, acc_i;

  logic                   wr_ok_c;
  logic                   last_issue_c;
  logic [HIW-1:0]         hidx_c;
  logic [AIW-1:0]         aidx_c;
  logic [31:0]            pidx_c;
  logic signed [ACW-1:0]  acc_r_nx_c, acc_i_nx_c;

`ifdef HQA_SAT_EN
  localparam logic signed [ACW-1:0] SAT_MAX = {{(ACW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACW-1:0] SAT_MIN = {{(ACW-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

  // Reduce an accumulator value to one DW-bit P element
  function automatic logic [DW-1:0] reduce(input logic signed [ACW-1:0] v);
`ifdef HQA_SAT_EN
    if (v > SAT_MAX)      return DW'(SAT_MAX);
    else if (v < SAT_MIN) return DW'(SAT_MIN);
    else                  return DW'(v);
`else
    return DW'(v);
`endif
  endfunction

  // Write acceptance, issue addressing and accumulation next-values
  always_comb begin
    wr_ok_c      = 1'b0;
    if (wr_en && (state == IDLE || state == DONE))
      wr_ok_c = wr_sel ? (32'(wr_addr) < AN) : (32'(wr_addr) < HN);
    last_issue_c = (k == KW'(NC - 1)) && (r == RW'(NR - 1)) && (c == CW'(NCOL - 1));
    hidx_c       = HIW'(32'(r) * NR * 0 + 32'(r) * NC + 32'(k));
    aidx_c       = AIW'(32'(k) * NCOL + 32'(c));
    pidx_c       = 32'(s2_c) * NR + 32'(s2_r);
    acc_r_nx_c   = s2_first ? '0 : acc_r;
    acc_i_nx_c   = s2_first ? '0 : acc_i;
    acc_r_nx_c   = acc_r_nx_c + ACW'(s2_pr);
    acc_i_nx_c   = acc_i_nx_c + ACW'(s2_pi);
  end

  // Control FSM: issue counters, drain timing, busy/done handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      r     <= '0;
      c     <= '0;
      dcnt  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            k     <= '0;
            r     <= '0;
            c     <= '0;
          end
        end
        RUN: begin
          if (last_issue_c) begin
            state <= DRAIN;
            dcnt  <= 1'b0;
          end else if (k != KW'(NC - 1)) begin
            k <= k + KW'(1);
          end else begin
            k <= '0;
            if (r != RW'(NR - 1)) begin
              r <= r + RW'(1);
            end else begin
              r <= '0;
              c <= c + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (dcnt) state <= DONE;
          else      dcnt  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // H/A register files and write-reject flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(HN); i++) begin
        h_r[i] <= '0;
        h_i[i] <= '0;
      end
      for (int i = 0; i < int'(AN); i++) begin
        a_r[i] <= '0;
        a_i[i] <= '0;
      end
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_ok_c;
      if (wr_ok_c) begin
        if (wr_sel) begin
          a_r[AIW'(wr_addr)] <= wr_data_r;
          a_i[AIW'(wr_addr)] <= wr_data_i;
        end else begin
          h_r[HIW'(wr_addr)] <= wr_data_r;
          h_i[HIW'(wr_addr)] <= wr_data_i;
        end
      end
    end
  end

  // Complex multiplier (products, then combine and scale) and accumulator into P
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_r     <= '0;
      s1_c     <= '0;
      s1_rr    <= '0;
      s1_ii    <= '0;
      s1_ri    <= '0;
      s1_ir    <= '0;
      s2_v     <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_r     <= '0;
      s2_c     <= '0;
      s2_pr    <= '0;
      s2_pi    <= '0;
      acc_r    <= '0;
      acc_i    <= '0;
      p_r      <= '0;
      p_i      <= '0;
    end else begin
      s1_v     <= (state == RUN);
      s1_first <= (k == '0);
      s1_last  <= (k == KW'(NC - 1));
      s1_r     <= r;
      s1_c     <= c;
      s1_rr    <= MW'(h_r[hidx_c]) * MW'(a_r[aidx_c]);
      s1_ii    <= MW'(h_i[hidx_c]) * MW'(a_i[aidx_c]);
      s1_ri    <= MW'(h_r[hidx_c]) * MW'(a_i[aidx_c]);
      s1_ir    <= MW'(h_i[hidx_c]) * MW'(a_r[aidx_c]);
      s2_v     <= s1_v;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_r     <= s1_r;
      s2_c     <= s1_c;
      s2_pr    <= (PW'(s1_rr) - PW'(s1_ii)) >>> FW;
      s2_pi    <= (PW'(s1_ri) + PW'(s1_ir)) >>> FW;
      if (s2_v) begin
        acc_r <= acc_r_nx_c;
        acc_i <= acc_i_nx_c;
      end
      for (int e = 0; e < int'(PN); e++) begin
        if (s2_v && s2_last && pidx_c == 32'(e)) begin
          p_r[e*DW +: DW] <= reduce(acc_r_nx_c);
          p_i[e*DW +: DW] <= reduce(acc_i_nx_c);
        end
      end
    end
  end

endmodule

// File: tb/tb_hmat_colmult_engine.sv
// Scoreboard bench for hmat_colmult_engine at default parameters (Q8.8, 4x2 by 2x2).
module tb_hmat_colmult_engine;

  localparam int unsigned DW  = 16;
  localparam int unsigned NR  = 4;
  localparam int unsigned NC  = 2;
  localparam int unsigned NCOL = 2;
  localparam int unsigned PWB = NCOL * NR * DW;
  localparam int LAT = 19;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wr_en = 1'b0;
  logic           wr_sel = 1'b0;
  logic [2:0]     wr_addr = '0;
  logic [DW-1:0]  wr_data_r = '0;
  logic [DW-1:0]  wr_data_i = '0;
  logic           wr_err;
  logic           start = 1'b0;
  logic           busy;
  logic           done;
  logic [PWB-1:0] p_r;
  logic [PWB-1:0] p_i;

  hmat_colmult_engine dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data_r(wr_data_r), .wr_data_i(wr_data_i), .wr_err(wr_err), .start(start),
    .busy(busy), .done(done), .p_r(p_r), .p_i(p_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string          name;
    int             se;
    logic [127:0]   pr;
    logic [127:0]   pi;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;

  // H test data in P packing order: element k*NR + r holds H(r,k)
  logic [15:0] hc_re [8] = '{16'hffdd, 16'hffba, 16'hff9c, 16'h00db,
                             16'h0183, 16'h00b7, 16'h0005, 16'hffad};
  logic [15:0] hc_im [8] = '{16'h00c1, 16'hff4a, 16'hff2a, 16'h000c,
                             16'hfff4, 16'h003f, 16'hfea3, 16'hffea};
  logic [15:0] hc_nim [8] = '{16'hff3f, 16'h00b6, 16'h00d6, 16'hfff4,
                              16'h000c, 16'hffc1, 16'h015d, 16'h0016};

  function automatic logic [127:0] pack(input logic [15:0] v [8]);
    logic [127:0] p;
    p = '0;
    for (int e = 0; e < 8; e++) p[e*16 +: 16] = v[e];
    return p;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic wr(input logic sel, input int addr, input logic [15:0] dr, input logic [15:0] di);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 3'(addr); wr_data_r = dr; wr_data_i = di;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic do_start(output int se);
    start = 1'b1;
    @(posedge clk); #1;
    se = cyc;
    start = 1'b0;
  endtask

  task automatic push(input string nm, input int se, input logic [127:0] pr, input logic [127:0] pi);
    exp_t it;
    it.name = nm; it.se = se; it.pr = pr; it.pi = pi;
    sbq.push_back(it);
  endtask

  task automatic wait_done(input int lim);
    bit got;
    got = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done within %0d cycles, required done", lim);
    end
  endtask

  task automatic load_h_test();
    for (int a = 0; a < 8; a++) wr(1'b0, a, hc_re[(a % 2) * 4 + a / 2], hc_im[(a % 2) * 4 + a / 2]);
  endtask

  task automatic load_a_diag(input logic [15:0] dr, input logic [15:0] di);
    wr(1'b1, 0, dr, di);
    wr(1'b1, 1, 16'h0000, 16'h0000);
    wr(1'b1, 2, 16'h0000, 16'h0000);
    wr(1'b1, 3, dr, di);
  endtask

  // Output monitor: on every done, pop the oldest expectation and compare P, latency, busy length
  task automatic monitor();
    exp_t it;
    int busy_cnt;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done at cycle %0d, required no done", cyc);
          end else begin
            it = sbq.pop_front();
            chk({it.name, "_p_r"}, p_r, it.pr);
            chk({it.name, "_p_i"}, p_i, it.pi);
            chk({it.name, "_latency"}, 128'(cyc - it.se), 128'(LAT));
            chk({it.name, "_busy_cycles"}, 128'(busy_cnt), 128'(LAT));
            chk({it.name, "_busy_low_at_done"}, 128'(busy), 128'(0));
          end
          busy_cnt = 0;
        end
      end
    end
  endtask

  logic [127:0] id_pr, id_pi, j_pr, j_pi, ov_pr;
  int se;

  initial begin
    fork
      monitor();
    join_none

    id_pr = pack(hc_re);
    id_pi = pack(hc_im);
    j_pr  = pack(hc_nim);
    j_pi  = pack(hc_re);
`ifdef HQA_SAT_EN
    ov_pr = {8{16'h7fff}};
`else
    ov_pr = {8{16'hfe00}};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_wr_err", 128'(wr_err), 128'(0));
    chk("rst_p_r", p_r, 128'(0));
    chk("rst_p_i", p_i, 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity A: P = H
    load_h_test();
    load_a_diag(16'h0100, 16'h0000);
    chk("valid_write_no_err", 128'(wr_err), 128'(0));
    do_start(se);
    push("identity", se, id_pr, id_pi);
    wait_done(40);

    // A = jI, last A element written in the same cycle as start
    wr(1'b1, 0, 16'h0000, 16'h0100);
    wr(1'b1, 1, 16'h0000, 16'h0000);
    wr(1'b1, 2, 16'h0000, 16'h0000);
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 3'd3; wr_data_r = 16'h0000; wr_data_i = 16'h0100;
    do_start(se);
    wr_en = 1'b0;
    chk("write_with_start_no_err", 128'(wr_err), 128'(0));
    push("j_identity", se, j_pr, j_pi);
    wait_done(40);

    // Protocol: start ignored mid-run, write rejected while busy, out-of-range A writes
    load_a_diag(16'h0100, 16'h0000);
    do_start(se);
    push("ignored_start", se, id_pr, id_pi);
    repeat (4) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wr(1'b0, 0, 16'h1234, 16'h5678);
    chk("busy_write_err", 128'(wr_err), 128'(1));
    @(posedge clk); #1;
    chk("wr_err_one_cycle", 128'(wr_err), 128'(0));
    wait_done(40);
    wr(1'b1, 4, 16'h1111, 16'h2222);
    chk("a_addr4_err", 128'(wr_err), 128'(1));
    wr(1'b1, 7, 16'h3333, 16'h4444);
    chk("a_addr7_err", 128'(wr_err), 128'(1));
    do_start(se);
    push("readback_unchanged", se, id_pr, id_pi);
    wait_done(40);

    // Overflow
    for (int a = 0; a < 8; a++) wr(1'b0, a, 16'h7fff, 16'h0000);
    for (int a = 0; a < 4; a++) wr(1'b1, a, 16'h7fff, 16'h0000);
    do_start(se);
    push("overflow", se, ov_pr, 128'(0));
    wait_done(40);

    // Back-to-back: start in the cycle right after done
    do_start(se);
    push("back_to_back", se, ov_pr, 128'(0));
    @(posedge clk); #1;
    chk("p_r_stable_after_restart", p_r, ov_pr);
    chk("p_i_stable_after_restart", p_i, 128'(0));
    wait_done(40);

    // Async reset mid-run
    do_start(se);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 128'(busy), 128'(0));
    chk("async_rst_done", 128'(done), 128'(0));
    chk("async_rst_wr_err", 128'(wr_err), 128'(0));
    chk("async_rst_p_r", p_r, 128'(0));
    chk("async_rst_p_i", p_i, 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(se);
    push("cleared_files", se, 128'(0), 128'(0));
    wait_done(40);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 128'(sbq.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
